// File: rtl/data_mem_resp.sv
// Data-memory responder for the CPU MEM stage: fixed-latency word read/write with error flagging.
// Latency: rdy pulses in the cycle after the LATENCY-th rising edge, counting the accepting edge.
// Backpressure: stall holds the pipeline while a request waits in IDLE or an access is in BUSY.
module data_mem_resp #(
  parameter int LATENCY = 4,
  parameter int AW      = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [15:0] address,
  input  logic [15:0] writeData,
  output logic [15:0] readData,
  output logic        rdy,
  output logic        stall,
  output logic        err,
  output logic [15:0] accCnt
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_rd;
  logic        r_wr;
  logic [15:0] r_addr;
  logic [15:0] r_wdata;
  logic [15:0] r_rdata;
  logic        r_rdy;
  logic        r_err;
  logic [15:0] r_acc;

  // Storage is not reset; contents are undefined until written.
  logic [15:0] r_mem [2**AW];

  logic          w_req;
  logic          w_in_idle;
  logic          w_src_rd;
  logic          w_src_wr;
  logic [15:0]   w_src_addr;
  logic [15:0]   w_src_wdata;
  logic          w_oor;
  logic [AW-1:0] w_idx;
  logic          w_go_done;
  logic          w_do_write;
  logic          w_do_read;
  logic          w_acc_err;

  assign w_req     = memRead | memWrite;
  assign w_in_idle = (r_state == IDLE);

  // With LATENCY==1 the access executes at the accepting edge, before the
  // latch registers hold the request, so take the live inputs in IDLE.
  assign w_src_rd    = w_in_idle ? memRead   : r_rd;
  assign w_src_wr    = w_in_idle ? memWrite  : r_wr;
  assign w_src_addr  = w_in_idle ? address   : r_addr;
  assign w_src_wdata = w_in_idle ? writeData : r_wdata;

  assign w_oor     = (w_src_addr >> AW) != 16'd0;
  assign w_idx     = w_src_addr[AW-1:0];
  assign w_go_done = (w_in_idle && w_req && (LATENCY == 1)) ||
                     ((r_state == BUSY) && (r_cnt == 4'd1));

  // A simultaneous read+write is treated as a write; readData is untouched.
  assign w_do_write = w_go_done & w_src_wr & ~w_oor;
  assign w_do_read  = w_go_done & w_src_rd & ~w_src_wr;
  assign w_acc_err  = w_oor | (w_src_rd & w_src_wr);

  assign stall    = rst_n & ((w_in_idle & w_req) | (r_state == BUSY));
  assign readData = r_rdata;
  assign rdy      = r_rdy;
  assign err      = r_err;
  assign accCnt   = r_acc;

  // Storage write at the edge entering DONE; suppressed while reset is asserted.
  always_ff @(posedge clk) begin
    if (rst_n && w_do_write) begin
      r_mem[w_idx] <= w_src_wdata;
    end
  end

  // Access FSM with latched request, completion pulses, read data and access counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 4'd0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_addr  <= 16'd0;
      r_wdata <= 16'd0;
      r_rdata <= 16'd0;
      r_rdy   <= 1'b0;
      r_err   <= 1'b0;
      r_acc   <= 16'd0;
    end else begin
      r_rdy <= w_go_done;
      r_err <= w_go_done & w_acc_err;
      if (w_do_read) begin
        r_rdata <= w_oor ? 16'h0000 : r_mem[w_idx];
      end
      if (w_go_done && (r_acc != 16'hFFFF)) begin
        r_acc <= r_acc + 16'd1;
      end
      case (r_state)
        IDLE: begin
          if (w_req) begin
            r_rd    <= memRead;
            r_wr    <= memWrite;
            r_addr  <= address;
            r_wdata <= writeData;
            if (LATENCY == 1) begin
              r_state <= DONE;
            end else begin
              r_state <= BUSY;
              r_cnt   <= LAT_M1;
            end
          end
        end
        BUSY: begin
          if (r_cnt == 4'd1) begin
            r_state <= DONE;
            r_cnt   <= 4'd0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_resp.sv
// Directed bench for data_mem_resp: a LATENCY=4 instance for the main sequence
// and a LATENCY=1 instance for back-to-back held requests.
// Outputs are sampled 1 time unit after the rising edge.
module tb_data_mem_resp;

  logic        clk;
  logic        rst_n;
  logic        rd4, wr4;
  logic [15:0] addr4, wd4;
  logic [15:0] rdata4, cnt4;
  logic        rdy4, stall4, err4;
  logic        rd1, wr1;
  logic [15:0] addr1, wd1;
  logic [15:0] rdata1, cnt1;
  logic        rdy1, stall1, err1;

  int total = 0;
  int bad   = 0;

  // results of the last access() call
  int          t_edges;
  int          t_stalls;
  logic        t_err;
  logic [15:0] t_rdata;
  logic        t_stall_done;
  logic        t_rdy_after;

  data_mem_resp #(.LATENCY(4), .AW(12)) u4 (
    .clk(clk), .rst_n(rst_n), .memRead(rd4), .memWrite(wr4),
    .address(addr4), .writeData(wd4), .readData(rdata4),
    .rdy(rdy4), .stall(stall4), .err(err4), .accCnt(cnt4)
  );

  data_mem_resp #(.LATENCY(1), .AW(12)) u1 (
    .clk(clk), .rst_n(rst_n), .memRead(rd1), .memWrite(wr1),
    .address(addr1), .writeData(wd1), .readData(rdata1),
    .rdy(rdy1), .stall(stall1), .err(err1), .accCnt(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one request on the LATENCY=4 instance and hold it until rdy.
  task automatic access(input logic r, input logic w, input logic [15:0] a, input logic [15:0] d);
    rd4 = r; wr4 = w; addr4 = a; wd4 = d;
    t_edges = 0; t_stalls = 0;
    #1;
    if (stall4) t_stalls++;
    while (t_edges < 20) begin
      @(posedge clk); #1;
      t_edges++;
      if (rdy4) break;
      if (stall4) t_stalls++;
    end
    t_stall_done = stall4;
    t_err        = err4;
    t_rdata      = rdata4;
    rd4 = 1'b0; wr4 = 1'b0;
    @(posedge clk); #1;
    t_rdy_after = rdy4;
  endtask

  initial begin
    logic [7:0] trace;
    int         idx;
    logic       prev;
    rst_n = 1'b0;
    rd4 = 0; wr4 = 0; addr4 = 0; wd4 = 0;
    rd1 = 0; wr1 = 0; addr1 = 0; wd1 = 0;
    #12;
    // reset state, stall suppressed despite a request
    rd4 = 1'b1; addr4 = 16'h0010;
    #1;
    chk("rst_stall", stall4, 1'b0);
    chk("rst_rdy", rdy4, 1'b0);
    chk("rst_err", err4, 1'b0);
    chk("rst_cnt", cnt4, 16'h0000);
    chk("rst_rdata", rdata4, 16'h0000);
    rd4 = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // write BEEF @0010
    access(1'b0, 1'b1, 16'h0010, 16'hBEEF);
    chk("w1_edges", t_edges, 4);
    chk("w1_stalls", t_stalls, 4);
    chk("w1_stall_done", t_stall_done, 1'b0);
    chk("w1_err", t_err, 1'b0);
    chk("w1_rdata", t_rdata, 16'h0000);
    chk("w1_rdy_pulse", t_rdy_after, 1'b0);
    chk("w1_cnt", cnt4, 16'd1);

    // read back
    access(1'b1, 1'b0, 16'h0010, 16'h0000);
    chk("r1_edges", t_edges, 4);
    chk("r1_rdata", t_rdata, 16'hBEEF);
    chk("r1_err", t_err, 1'b0);
    chk("r1_cnt", cnt4, 16'd2);

    // write to same address leaves readData alone
    access(1'b0, 1'b1, 16'h0010, 16'h1111);
    chk("w2_rdata_held", t_rdata, 16'hBEEF);
    chk("w2_rdata_after", rdata4, 16'hBEEF);
    chk("w2_cnt", cnt4, 16'd3);

    // no stale read
    access(1'b1, 1'b0, 16'h0010, 16'h0000);
    chk("r2_rdata", t_rdata, 16'h1111);

    // define word 0, then out-of-range read and write
    access(1'b0, 1'b1, 16'h0000, 16'h7777);
    access(1'b1, 1'b0, 16'hF000, 16'h0000);
    chk("oor_r_rdata", t_rdata, 16'h0000);
    chk("oor_r_err", t_err, 1'b1);
    chk("oor_r_edges", t_edges, 4);
    access(1'b0, 1'b1, 16'hF000, 16'h9999);
    chk("oor_w_err", t_err, 1'b1);
    access(1'b1, 1'b0, 16'h0000, 16'h0000);
    chk("word0_kept", t_rdata, 16'h7777);
    chk("word0_err", t_err, 1'b0);
    chk("cnt_after_oor", cnt4, 16'd8);

    // simultaneous read+write performs the write
    access(1'b1, 1'b1, 16'h0002, 16'h1234);
    chk("both_err", t_err, 1'b1);
    chk("both_rdata", t_rdata, 16'h7777);
    access(1'b1, 1'b0, 16'h0002, 16'h0000);
    chk("both_readback", t_rdata, 16'h1234);
    chk("cnt_10", cnt4, 16'd10);

    // reset during BUSY abandons a write
    access(1'b0, 1'b1, 16'h0003, 16'hAAAA);
    wr4 = 1'b1; addr4 = 16'h0003; wd4 = 16'h5555;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("busy2_stall", stall4, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rdy", rdy4, 1'b0);
    chk("mid_rst_cnt", cnt4, 16'h0000);
    chk("mid_rst_stall", stall4, 1'b0);
    chk("mid_rst_rdata", rdata4, 16'h0000);
    wr4 = 1'b0; rd4 = 1'b1; wd4 = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    chk("in_rst_rdy", rdy4, 1'b0);
    chk("in_rst_stall", stall4, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    // read held through reset is accepted at the first edge
    access(1'b1, 1'b0, 16'h0003, 16'h0000);
    chk("post_rst_edges", t_edges, 4);
    chk("post_rst_rdata", t_rdata, 16'hAAAA);
    chk("post_rst_cnt", cnt4, 16'd1);

    // LATENCY=1: write 00AA@5, write 00BB@6, read @5, CPU advances after DONE
    trace = 8'h00; idx = 0; prev = 1'b0;
    wr1 = 1'b1; addr1 = 16'h0005; wd1 = 16'h00AA;
    for (int e = 0; e < 8; e++) begin
      @(posedge clk); #1;
      trace[e] = rdy1;
      if (!rdy1 && prev) begin
        idx++;
        rd1 = 1'b0; wr1 = 1'b0;
        if (idx == 1) begin wr1 = 1'b1; addr1 = 16'h0006; wd1 = 16'h00BB; end
        if (idx == 2) begin rd1 = 1'b1; addr1 = 16'h0005; wd1 = 16'h0000; end
      end
      prev = rdy1;
    end
    chk("l1_rdy_trace", trace, 8'b0001_0101);
    chk("l1_cnt", cnt1, 16'd3);
    chk("l1_rdata", rdata1, 16'h00AA);
    chk("l1_err", err1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
